psa_simd_pipe: RTL and testbench
================================

Name: psa_simd_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit parallel sub-word adder.
- Splits a DATA_W word into NUM_LANES = DATA_W/LANE_W signed lanes and performs one of four operations per lane: add, subtract, accumulate into an internal register, or clear the accumulator.
- Every arithmetic result is saturated per lane and comes with a per-lane overflow flag.
- Sits behind the decode stage as the SIMD execute unit, using a valid/ready handshake on both sides.

Parameters:
- DATA_W, 16: total operand and result width; must be a multiple of LANE_W.
- LANE_W, 4: width of one signed lane; must be >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  unit can accept this cycle.
- in_op  input  2  operation: 00 add A+B, 01 sub A-B, 10 accumulate acc+A, 11 clear acc.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B; ignored for ops 10 and 11.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  DATA_W  saturated lane results.
- out_ovfl  output  DATA_W/LANE_W  per-lane overflow; bit i covers lane bits [i*LANE_W +: LANE_W].
- sticky_ovfl  output  1  set when any overflow has occurred since the last clear.
- clr_sticky  input  1  clears sticky_ovfl.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - Resets both stage valids, the accumulator, out_sum, out_ovfl and sticky_ovfl to 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight data; no out_valid is produced for it.
- Pipeline: two stages, S1 and S2. The S2 register drives the outputs.
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en, combinational from the stage state and out_ready.
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - A result appears on out_valid exactly 2 cycles after acceptance when there is no backpressure.
  - Sustained throughput is 1 result per cycle.
- Stalls and ordering:
  - While out_valid=1 and out_ready=0, out_sum and out_ovfl hold stable.
  - Up to 2 results are buffered, in_ready goes low, and nothing is dropped or reordered.
- S1 (ops 00/01):
  - Computes the raw per-lane result in LANE_W+1 bits, sign-extending both operands.
  - Sub is computed as A + ~B + 1 per lane.
  - No carry propagates between lanes.
- S2 (loads when s2_en & s1_valid): saturates each lane.
  - If the top two bits of the LANE_W+1 result differ, the lane becomes max positive (0111..) when the true result is positive, or min negative (1000..) when negative, and out_ovfl[i]=1.
  - Otherwise the lane is the low LANE_W bits and out_ovfl[i]=0.
- Accumulate (op 10):
  - Evaluated in S2 at load time using the current acc: result = sat(acc + A) per lane.
  - acc <= result in the same edge.
  - Back-to-back accumulates chain correctly with no bubbles.
- Clear (op 11):
  - acc <= 0 at S2 load.
  - Emits one result with out_sum=0 and out_ovfl=0.
- sticky_ovfl:
  - Set at an S2 load whose out_ovfl is nonzero.
  - Cleared by clr_sticky=1.
  - If a set and clr_sticky occur on the same edge, set wins.
- Ops 00/01 never modify acc.
- Illegal parameters (DATA_W % LANE_W != 0, or LANE_W < 2) stop elaboration with an error.

Test Plan (DATA_W=16, LANE_W=4):
- Add, no backpressure: A=0x1234, B=0x1111 -> out_sum 0x2345, out_ovfl 4'b0000, out_valid exactly 2 cycles after acceptance, sticky_ovfl stays 0.
- Positive saturation: add A=0x7777, B=0x1111 -> out_sum 0x7777, out_ovfl 4'b1111, sticky_ovfl=1. Then clr_sticky pulse -> sticky_ovfl=0. Then clr_sticky together with another overflowing add -> sticky_ovfl=1.
- Negative saturation, sub: A=0x8000, B=0x1000 -> out_sum 0x8000, out_ovfl 4'b1000. Sub A=0x0123, B=0x0111 -> 0x0012, ovfl 4'b0000.
- Accumulate: op 11, then three back-to-back op 10 with A=0x3333 -> results 0x0000, 0x3333, 0x6666, 0x7777. out_ovfl is 0, 0, 0, 4'b1111 on consecutive cycles. acc afterwards is 0x7777.
- Backpressure: out_ready=0 while 3 adds are offered back-to-back -> first 2 accepted, in_ready=0 on the third, out_sum held stable. Set out_ready=1 -> all 3 results emerge in order, one per cycle, none lost.
- Reset mid-operation: assert rst for 1 cycle with 2 results in flight and acc=0x3333 -> out_valid=0, acc=0, sticky_ovfl=0, in_ready=1 next cycle. A following accumulate of A=0x1111 yields 0x1111.

Source files
------------

// File: rtl/psa_simd_pipe.sv
// Two-stage SIMD execute unit: per-lane signed add/sub/accumulate/clear with
// saturation, per-lane overflow flags and a sticky overflow bit.
module psa_simd_pipe #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_sum,
  output logic [DATA_W/LANE_W-1:0] out_ovfl,
  output logic                     sticky_ovfl,
  input  logic                     clr_sticky
);

  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int RAW_W     = NUM_LANES * (LANE_W + 1);

  if (((DATA_W % LANE_W) != 0) || (LANE_W < 2)) begin : g_bad_params
    $error("psa_simd_pipe: DATA_W must be a multiple of LANE_W and LANE_W must be >= 2");
  end

  // Lane-local add in LANE_W+1 bits; subtraction as x + ~y + 1.
  function automatic logic [LANE_W:0] lane_add(input logic [LANE_W-1:0] x,
                                               input logic [LANE_W-1:0] y,
                                               input logic              sub);
    logic signed [LANE_W:0] xe;
    logic signed [LANE_W:0] ye;
    xe = {x[LANE_W-1], x};
    ye = {y[LANE_W-1], y};
    if (sub) lane_add = xe + ~ye + (LANE_W+1)'(1);
    else     lane_add = xe + ye;
  endfunction

  // Returns {overflow, saturated lane value}.
  function automatic logic [LANE_W:0] lane_sat(input logic [LANE_W:0] raw);
    if (raw[LANE_W] != raw[LANE_W-1])
      lane_sat = {1'b1, raw[LANE_W], {(LANE_W-1){~raw[LANE_W]}}};
    else
      lane_sat = {1'b0, raw[LANE_W-1:0]};
  endfunction

  logic              s1_valid_q, s2_valid_q;
  logic [1:0]        s1_op_q;
  logic [RAW_W-1:0]  s1_raw_d, s1_raw_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] acc_d, acc_q;
  logic [DATA_W-1:0] sum_sat, out_sum_d, out_sum_q;
  logic [NUM_LANES-1:0] ovfl_sat, out_ovfl_d, out_ovfl_q;
  logic              sticky_d, sticky_q;
  logic              s1_en, s2_en, s2_load;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign s2_load  = s2_en && s1_valid_q;
  assign in_ready = s1_en;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W:0] acc_raw;
    logic [LANE_W:0] sat_r;
    assign s1_raw_d[i*(LANE_W+1) +: (LANE_W+1)] =
      lane_add(in_a[i*LANE_W +: LANE_W], in_b[i*LANE_W +: LANE_W], in_op[0]);
    assign acc_raw = lane_add(acc_q[i*LANE_W +: LANE_W], s1_a_q[i*LANE_W +: LANE_W], 1'b0);
    assign sat_r   = lane_sat(s1_op_q[1] ? acc_raw : s1_raw_q[i*(LANE_W+1) +: (LANE_W+1)]);
    assign sum_sat[i*LANE_W +: LANE_W] = sat_r[LANE_W-1:0];
    assign ovfl_sat[i] = sat_r[LANE_W];
  end

  always_comb begin
    out_sum_d  = sum_sat;
    out_ovfl_d = ovfl_sat;
    acc_d      = acc_q;
    if (s1_op_q == 2'b11) begin
      out_sum_d  = '0;
      out_ovfl_d = '0;
      acc_d      = '0;
    end else if (s1_op_q == 2'b10) begin
      acc_d = sum_sat;
    end
    sticky_d = sticky_q;
    if (s2_load && (|out_ovfl_d)) sticky_d = 1'b1;
    else if (clr_sticky)          sticky_d = 1'b0;
  end

  // ---- S1 operand/raw-result register ----
  always_ff @(posedge clk) begin
    if (s1_en) begin
      s1_op_q  <= in_op;
      s1_raw_q <= s1_raw_d;
      s1_a_q   <= in_a;
    end
  end

  // ---- S1/S2 control, accumulator and output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      out_sum_q  <= '0;
      out_ovfl_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= in_valid;
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        out_sum_q  <= out_sum_d;
        out_ovfl_q <= out_ovfl_d;
        acc_q      <= acc_d;
      end
      sticky_q <= sticky_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_sum     = out_sum_q;
  assign out_ovfl    = out_ovfl_q;
  assign sticky_ovfl = sticky_q;

endmodule

// File: tb/tb_psa_simd_pipe.sv
// Directed, table-driven bench for psa_simd_pipe (DATA_W=16, LANE_W=4).
module tb_psa_simd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_ovfl;
  logic        sticky_ovfl;
  logic        clr_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  psa_simd_pipe #(.DATA_W(16), .LANE_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovfl(out_ovfl),
    .sticky_ovfl(sticky_ovfl), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [3:0]  ovfl;
    logic        sticky;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single transaction into an empty pipe with out_ready=1; checks 2-cycle latency.
  task automatic send(input string nm, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] es, input logic [3:0] eo);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_sum"}, 32'(out_sum), 32'(es));
    chk({nm, "_ovfl"}, 32'(out_ovfl), 32'(eo));
  endtask

  logic [15:0] acc_exp_sum [4];
  logic [3:0]  acc_exp_ovf [4];

  initial begin
    tbl[0]  = '{2'b00, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 1'b0};
    tbl[1]  = '{2'b01, 16'h0123, 16'h0111, 16'h0012, 4'b0000, 1'b0};
    tbl[2]  = '{2'b00, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0000, 1'b0};
    tbl[3]  = '{2'b00, 16'h7777, 16'h1111, 16'h7777, 4'b1111, 1'b1};
    tbl[4]  = '{2'b01, 16'h8000, 16'h1000, 16'h8000, 4'b1000, 1'b1};
    tbl[5]  = '{2'b00, 16'h8888, 16'h8888, 16'h8888, 4'b1111, 1'b1};
    tbl[6]  = '{2'b01, 16'h7000, 16'h9000, 16'h7000, 4'b1000, 1'b1};
    tbl[7]  = '{2'b11, 16'hABCD, 16'h1234, 16'h0000, 4'b0000, 1'b1};
    tbl[8]  = '{2'b10, 16'h3333, 16'hFFFF, 16'h3333, 4'b0000, 1'b1};
    tbl[9]  = '{2'b10, 16'h3333, 16'h0000, 16'h6666, 4'b0000, 1'b1};
    tbl[10] = '{2'b10, 16'h3333, 16'h5555, 16'h7777, 4'b1111, 1'b1};
    tbl[11] = '{2'b10, 16'h9999, 16'h0000, 16'h0000, 4'b0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovfl", 32'(out_ovfl), 32'd0);
    chk("rst_sticky", 32'(sticky_ovfl), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].ovfl);
      chk($sformatf("vec%0d_sticky", i), 32'(sticky_ovfl), 32'(tbl[i].sticky));
    end

    // Sticky clear, then clear coinciding with a new overflow (set wins).
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("clr_sticky", 32'(sticky_ovfl), 32'd0);
    in_valid = 1'b1; in_op = 2'b00; in_a = 16'h7777; in_b = 16'h1111;
    step();
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("set_wins_sticky", 32'(sticky_ovfl), 32'd1);
    chk("set_wins_valid", 32'(out_valid), 32'd1);
    chk("set_wins_sum", 32'(out_sum), 32'h7777);
    step();

    // Clear followed by three back-to-back accumulates.
    acc_exp_sum = '{16'h0000, 16'h3333, 16'h6666, 16'h7777};
    acc_exp_ovf = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_op = (c == 0) ? 2'b11 : 2'b10; in_a = 16'h3333; in_b = 16'h0000;
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) begin
        chk($sformatf("b2b%0d_valid", c-2), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d_sum", c-2), 32'(out_sum), 32'(acc_exp_sum[c-2]));
        chk($sformatf("b2b%0d_ovfl", c-2), 32'(out_ovfl), 32'(acc_exp_ovf[c-2]));
      end
      step();
    end
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third stalls, then all three drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 16'h1111; in_b = 16'h1111;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    step();
    in_a = 16'h0101; in_b = 16'h0202;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    in_a = 16'h1000; in_b = 16'h0001;
    chk("bp_rdy2_low", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_sum0", 32'(out_sum), 32'h2222);
    step();
    chk("bp_rdy3_low", 32'(in_ready), 32'd0);
    chk("bp_hold_sum1", 32'(out_sum), 32'h2222);
    chk("bp_hold_ovfl", 32'(out_ovfl), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out1_valid", 32'(out_valid), 32'd1);
    chk("bp_out1_sum", 32'(out_sum), 32'h0303);
    step();
    chk("bp_out2_valid", 32'(out_valid), 32'd1);
    chk("bp_out2_sum", 32'(out_sum), 32'h1001);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two results in flight and a nonzero accumulator.
    send("rs_clear", 2'b11, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    send("rs_acc", 2'b10, 16'h3333, 16'h0000, 16'h3333, 4'b0000);
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_a = 16'h1234; in_b = 16'h1111;
    step();
    in_a = 16'h0001; in_b = 16'h0001;
    step();
    in_valid = 1'b0;
    chk("rs_inflight", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    chk("rs_sticky", 32'(sticky_ovfl), 32'd0);
    chk("rs_sum", 32'(out_sum), 32'd0);
    chk("rs_ovfl", 32'(out_ovfl), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rs_no_ghost%0d", k), 32'(out_valid), 32'd0);
    end
    send("rs_acc_after", 2'b10, 16'h1111, 16'h0000, 16'h1111, 4'b0000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
